// File: rtl/fifo_cell_ctrl.sv
// Token-based sequencer for the cell FIFO array: one-hot put/get pointers,
// occupancy count, level flags and sticky error detection.
module fifo_cell_ctrl #(
  parameter  int N_CELLS  = 16,
  parameter  int AF_LEVEL = 12,
  parameter  int AE_LEVEL = 4,
  localparam int CW       = $clog2(N_CELLS + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               put_req_i,
  input  logic               get_req_i,
  input  logic [N_CELLS-1:0] e_i,
  input  logic               err_clr_i,
  output logic [N_CELLS-1:0] we_o,
  output logic [N_CELLS-1:0] re_o,
  output logic               put_ack_o,
  output logic               get_ack_o,
  output logic [CW-1:0]      count_o,
  output logic               full,
  output logic               empty,
  output logic               almost_full,
  output logic               almost_empty,
  output logic               ovf_err,
  output logic               unf_err,
  output logic               cell_err
);

  logic [N_CELLS-1:0] putPtr_q, putPtr_d;
  logic [N_CELLS-1:0] getPtr_q, getPtr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic               cell_q, cell_d;
  logic               active_q;
  logic               cellMismatch;

  // Level flags come straight from the registered count.
  assign full         = (count_q == CW'(N_CELLS));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CW'(AF_LEVEL));
  assign almost_empty = (count_q <= CW'(AE_LEVEL));
  assign count_o      = count_q;

  // active_q stays low through reset and the first edge after release,
  // so no strobe can escape in the release cycle.
  assign put_ack_o = put_req_i & active_q & ~full;
  assign get_ack_o = get_req_i & active_q & ~empty;
  assign we_o      = put_ack_o ? putPtr_q : '0;
  assign re_o      = get_ack_o ? getPtr_q : '0;

  assign ovf_err  = ovf_q;
  assign unf_err  = unf_q;
  assign cell_err = cell_q;

  assign cellMismatch = (count_q == '0) != (&e_i);

  always_comb begin
    putPtr_d = put_ack_o ? {putPtr_q[N_CELLS-2:0], putPtr_q[N_CELLS-1]} : putPtr_q;
    getPtr_d = get_ack_o ? {getPtr_q[N_CELLS-2:0], getPtr_q[N_CELLS-1]} : getPtr_q;
    count_d  = count_q;
    case ({put_ack_o, get_ack_o})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // A new error event takes priority over a coincident clear.
    ovf_d  = (ovf_q  & ~err_clr_i) | (put_req_i & full);
    unf_d  = (unf_q  & ~err_clr_i) | (get_req_i & empty);
    cell_d = (cell_q & ~err_clr_i) | cellMismatch;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      putPtr_q <= N_CELLS'(1);
      getPtr_q <= N_CELLS'(1);
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      cell_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      putPtr_q <= putPtr_d;
      getPtr_q <= getPtr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      cell_q   <= cell_d;
      active_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_cell_ctrl.sv
// Directed bench for fifo_cell_ctrl with a behavioural cell array driving e_i.
module tb_fifo_cell_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        put_req_i, get_req_i, err_clr_i;
  logic [15:0] e_i;
  logic [15:0] we_o, re_o;
  logic        put_ack_o, get_ack_o;
  logic [4:0]  count_o;
  logic        full, empty, almost_full, almost_empty;
  logic        ovf_err, unf_err, cell_err;

  logic [15:0] cells;
  logic        forceE;
  int          testsRun = 0;
  int          failCount = 0;
  int          expCount, putIdx, getIdx;

  fifo_cell_ctrl dut (
    .clk(clk), .reset(reset), .put_req_i(put_req_i), .get_req_i(get_req_i),
    .e_i(e_i), .err_clr_i(err_clr_i), .we_o(we_o), .re_o(re_o),
    .put_ack_o(put_ack_o), .get_ack_o(get_ack_o), .count_o(count_o),
    .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .ovf_err(ovf_err), .unf_err(unf_err),
    .cell_err(cell_err)
  );

  always #5 clk = ~clk;

  // Behavioural cell array: a write fills a cell, a read empties it.
  always @(posedge clk or posedge reset) begin
    if (reset) cells <= '1;
    else       cells <= (cells & ~we_o) | re_o;
  end
  assign e_i = forceE ? 16'hFFFF : cells;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic put, input logic get);
    put_req_i = put;
    get_req_i = get;
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [15:0] rotl(input logic [15:0] v, input int n);
    logic [15:0] r;
    r = v;
    for (int k = 0; k < n; k++) r = {r[14:0], r[15]};
    return r;
  endfunction

  task automatic checkFlags(input string tag);
    checkOutput({tag, " full"},   32'(full),         32'(expCount == 16));
    checkOutput({tag, " empty"},  32'(empty),        32'(expCount == 0));
    checkOutput({tag, " afull"},  32'(almost_full),  32'(expCount >= 12));
    checkOutput({tag, " aempty"}, 32'(almost_empty), 32'(expCount <= 4));
  endtask

  // One cycle of traffic: checks acks/strobes before the edge, count after.
  task automatic doCycle(input logic put, input logic get, input string tag);
    logic putOk, getOk;
    logic [15:0] expWe, expRe;
    putOk = put && (expCount < 16);
    getOk = get && (expCount > 0);
    expWe = putOk ? (16'h0001 << putIdx) : 16'h0000;
    expRe = getOk ? (16'h0001 << getIdx) : 16'h0000;
    applyStimulus(put, get);
    #1;
    checkOutput({tag, " put_ack"}, 32'(put_ack_o), 32'(putOk));
    checkOutput({tag, " get_ack"}, 32'(get_ack_o), 32'(getOk));
    checkOutput({tag, " we"}, 32'(we_o), 32'(expWe));
    checkOutput({tag, " re"}, 32'(re_o), 32'(expRe));
    step();
    if (putOk) putIdx = (putIdx + 1) % 16;
    if (getOk) getIdx = (getIdx + 1) % 16;
    expCount = expCount + (putOk ? 1 : 0) - (getOk ? 1 : 0);
    checkOutput({tag, " count"}, 32'(count_o), 32'(expCount));
  endtask

  task automatic clearErrors;
    applyStimulus(1'b0, 1'b0);
    err_clr_i = 1'b1;
    step();
    err_clr_i = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    forceE = 1'b0;
    err_clr_i = 1'b0;
    expCount = 0; putIdx = 0; getIdx = 0;
    applyStimulus(1'b1, 1'b0);
    step();
    step();
    // Test 1: reset values, then release with a put pending
    checkOutput("rst put_ack", 32'(put_ack_o), 32'd0);
    checkOutput("rst we", 32'(we_o), 32'd0);
    checkOutput("rst count", 32'(count_o), 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("release we", 32'(we_o), 32'd0);
    checkOutput("release put_ack", 32'(put_ack_o), 32'd0);
    step();
    checkOutput("release count", 32'(count_o), 32'd0);
    applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step();
    checkFlags("idle");
    checkOutput("idle count", 32'(count_o), 32'd0);
    checkOutput("idle we", 32'(we_o), 32'd0);
    checkOutput("idle re", 32'(re_o), 32'd0);
    checkOutput("idle errs", 32'({ovf_err, unf_err, cell_err}), 32'd0);

    // Test 2: fill to full, then overflow
    for (int i = 0; i < 16; i++) begin
      doCycle(1'b1, 1'b0, "fill");
      checkFlags("fill");
    end
    doCycle(1'b1, 1'b0, "ovf");
    checkOutput("ovf_err set", 32'(ovf_err), 32'd1);
    checkOutput("unf_err quiet", 32'(unf_err), 32'd0);

    // Test 3: drain to empty, underflow, then clear
    for (int i = 0; i < 16; i++) begin
      doCycle(1'b0, 1'b1, "drain");
      checkFlags("drain");
    end
    doCycle(1'b0, 1'b1, "unf");
    checkOutput("unf_err set", 32'(unf_err), 32'd1);
    checkOutput("ovf_err held", 32'(ovf_err), 32'd1);
    clearErrors();
    checkOutput("clr ovf", 32'(ovf_err), 32'd0);
    checkOutput("clr unf", 32'(unf_err), 32'd0);
    applyStimulus(1'b0, 1'b1);
    err_clr_i = 1'b1;
    step();
    err_clr_i = 1'b0;
    checkOutput("set beats clr", 32'(unf_err), 32'd1);
    clearErrors();
    checkOutput("clr unf again", 32'(unf_err), 32'd0);

    // Test 4: steady state at count 5, pointers wrap
    for (int i = 0; i < 5; i++) doCycle(1'b1, 1'b0, "pre5");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b1);
      #1;
      checkOutput("ptr rel", 32'(we_o), 32'(rotl(re_o, 5)));
      doCycle(1'b1, 1'b1, "both5");
    end

    // Test 5: simultaneous put+get at full and at empty
    for (int i = 0; i < 11; i++) doCycle(1'b1, 1'b0, "tofull");
    doCycle(1'b1, 1'b1, "both@full");
    checkOutput("both@full ovf", 32'(ovf_err), 32'd1);
    for (int i = 0; i < 15; i++) doCycle(1'b0, 1'b1, "toempty");
    doCycle(1'b1, 1'b1, "both@empty");
    checkOutput("both@empty unf", 32'(unf_err), 32'd1);
    clearErrors();

    // Test 6: mid-stream reset at count 9, then cell cross-check
    for (int i = 0; i < 8; i++) doCycle(1'b1, 1'b0, "to9");
    checkOutput("count9", 32'(count_o), 32'd9);
    applyStimulus(1'b1, 1'b0);
    #2 reset = 1'b1;
    #1;
    checkOutput("midrst count", 32'(count_o), 32'd0);
    checkOutput("midrst empty", 32'(empty), 32'd1);
    checkOutput("midrst we", 32'(we_o), 32'd0);
    checkOutput("midrst put_ack", 32'(put_ack_o), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("midrel we", 32'(we_o), 32'd0);
    step();
    checkOutput("midrel count", 32'(count_o), 32'd0);
    expCount = 0; putIdx = 0; getIdx = 0;
    for (int i = 0; i < 3; i++) doCycle(1'b1, 1'b0, "to3");
    checkOutput("cell_err quiet", 32'(cell_err), 32'd0);
    applyStimulus(1'b0, 1'b0);
    forceE = 1'b1;
    step();
    forceE = 1'b0;
    checkOutput("cell_err set", 32'(cell_err), 32'd1);
    clearErrors();
    checkOutput("cell_err clr", 32'(cell_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
